// File: rtl/lcg_stim_source.sv
// Stimulus source that fills OUT_W-bit vectors from a 32-bit LCG behind a valid/ready handshake.
// Define LCG_STIM_SIG_EN to add a 32-bit rolling signature of accepted vectors on port sig.
module lcg_stim_source #(
  parameter int unsigned OUT_W = 137,
  parameter logic [31:0] SEED  = 32'd2167613558,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed_val,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             hold,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [OUT_W-1:0] vec_data,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             busy,
  output logic             done
`ifdef LCG_STIM_SIG_EN
  ,
  output logic [31:0]      sig
`endif
);

  localparam int unsigned NW    = (OUT_W + 31) / 32;
  localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StPresent, StDone} state_e;

  state_e           st_q, st_d;
  logic [31:0]      lcg_q, lcg_d, lcg_step;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, num_q, num_d, cnt_inc;
  logic             start_go, accept;

  assign lcg_step  = lcg_q * 32'h41C64E6D + 32'h0000_3039;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign start_go  = start && (st_q == StIdle || st_q == StDone);
  assign vec_valid = (st_q == StPresent);
  assign accept    = vec_valid && vec_ready;
  assign busy      = (st_q == StFill) || (st_q == StPresent);
  assign done      = (st_q == StDone);
  assign vec_cnt   = cnt_q;

  always_comb begin
    st_d  = st_q;
    lcg_d = lcg_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    num_d = num_q;
    case (st_q)
      StIdle, StDone: begin
        // Seed applies before a same-cycle start, so the run sees the new seed.
        if (st_q == StIdle && seed_load) lcg_d = seed_val;
        if (start_go) begin
          num_d = num_vec;
          cnt_d = '0;
          idx_d = '0;
          st_d  = StFill;
        end
      end
      StFill: begin
        lcg_d = lcg_step;
        if (idx_q == IDX_W'(NW - 1)) st_d = StPresent;
        else                         idx_d = idx_q + IDX_W'(1);
      end
      StPresent: begin
        if (vec_ready) begin
          cnt_d = cnt_inc;
          if (num_q != '0 && cnt_inc == num_q) begin
            st_d = StDone;
          end else if (!hold) begin
            idx_d = '0;
            st_d  = StFill;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= StIdle;
      lcg_q <= SEED;
      idx_q <= '0;
      cnt_q <= '0;
      num_q <= '0;
    end else begin
      st_q  <= st_d;
      lcg_q <= lcg_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
    end
  end

`ifdef LCG_STIM_SIG_EN
  logic [31:0] word_pad [NW];
`endif

  // One register per word; the top word holds only the bits that reach vec_data.
  for (genvar k = 0; k < NW; k++) begin : g_word
    localparam int unsigned WK = (k == NW - 1) ? OUT_W - 32 * (NW - 1) : 32;
    logic [WK-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
      end else if (st_q == StFill && idx_q == IDX_W'(k)) begin
        word_q <= lcg_step[WK-1:0];
      end
    end

    assign vec_data[32*k +: WK] = word_q;
`ifdef LCG_STIM_SIG_EN
    assign word_pad[k] = 32'(word_q);
`endif
  end

`ifdef LCG_STIM_SIG_EN
  logic [31:0] fold, sig_q;

  always_comb begin
    fold = '0;
    for (int k = 0; k < NW; k++) fold = fold ^ word_pad[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (start_go) begin
      sig_q <= '0;
    end else if (accept) begin
      sig_q <= {sig_q[30:0], sig_q[31]} ^ fold;
    end
  end

  assign sig = sig_q;
`endif

endmodule

// File: tb/tb_lcg_stim_source.sv
// Scoreboard bench for lcg_stim_source: a 137-bit default instance and a 64-bit instance
// with a 4-bit vector counter.
module tb_lcg_stim_source;

  localparam logic [31:0] SEED = 32'd2167613558;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 137-bit instance
  logic         b_rst_n, b_seed_load, b_start, b_hold, b_ready, b_valid, b_busy, b_done;
  logic [31:0]  b_seed_val, b_num, b_cnt;
  logic [136:0] b_data;
  // 64-bit instance, 4-bit counter
  logic         s_rst_n, s_seed_load, s_start, s_hold, s_ready, s_valid, s_busy, s_done;
  logic [31:0]  s_seed_val;
  logic [3:0]   s_num, s_cnt;
  logic [63:0]  s_data;
`ifdef LCG_STIM_SIG_EN
  logic [31:0]  b_sig, s_sig;
`endif

  lcg_stim_source u_big (
    .clk(clk), .rst_n(b_rst_n), .seed_load(b_seed_load), .seed_val(b_seed_val),
    .start(b_start), .num_vec(b_num), .hold(b_hold), .vec_valid(b_valid),
    .vec_ready(b_ready), .vec_data(b_data), .vec_cnt(b_cnt), .busy(b_busy), .done(b_done)
`ifdef LCG_STIM_SIG_EN
    , .sig(b_sig)
`endif
  );

  lcg_stim_source #(.OUT_W(64), .CNT_W(4)) u_small (
    .clk(clk), .rst_n(s_rst_n), .seed_load(s_seed_load), .seed_val(s_seed_val),
    .start(s_start), .num_vec(s_num), .hold(s_hold), .vec_valid(s_valid),
    .vec_ready(s_ready), .vec_data(s_data), .vec_cnt(s_cnt), .busy(s_busy), .done(s_done)
`ifdef LCG_STIM_SIG_EN
    , .sig(s_sig)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [159:0] exp_q [$];
  logic [31:0]  m_st;
  logic [159:0] v1, v2;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference LCG: fills one vector LSB word first, masking the top word.
  function automatic logic [159:0] gen_vec(input int ow, inout logic [31:0] st);
    logic [159:0] v = '0;
    int nw = (ow + 31) / 32;
    for (int k = 0; k < nw; k++) begin
      st = st * 32'h41C64E6D + 32'h0000_3039;
      v[32*k +: 32] = st;
    end
    for (int b = ow; b < 160; b++) v[b] = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input bit big, input int n, input bit hold_first, input bit rand_rdy,
                          input int budget);
    int acc = 0;
    int cyc = 0;
    bit held_v = 0;
    bit rdy, valid;
    logic [159:0] got, held, exp;
    while (acc < n && cyc < budget) begin
      got   = big ? 160'(b_data) : 160'(s_data);
      valid = big ? b_valid : s_valid;
      if (held_v && valid) check("stable", got, held);
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (big) begin
        // Start/seed pulses while busy must not disturb the run.
        b_ready     = rdy;
        b_start     = ($urandom_range(0, 7) == 0);
        b_num       = 32'd3;
        b_seed_load = ($urandom_range(0, 7) == 0);
        b_seed_val  = $urandom;
      end else begin
        s_ready = rdy;
        s_hold  = hold_first && (acc == 0);
      end
      if (valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 160'(0), 160'(1));
        end else begin
          exp = exp_q.pop_front();
          check(big ? "data137" : "data64", got, exp);
        end
        acc++;
        held_v = 0;
      end else if (valid) begin
        held   = got;
        held_v = 1;
      end else begin
        held_v = 0;
      end
      tick();
      cyc++;
    end
    b_ready = 0; b_start = 0; b_seed_load = 0; s_ready = 0; s_hold = 0;
    if (acc < n) check("timeout", 160'(acc), 160'(n));
  endtask

  task automatic small_reset();
    s_rst_n = 0;
    #2;
    s_rst_n = 1;
    tick();
    exp_q.delete();
  endtask

  initial begin
    b_rst_n = 0; b_seed_load = 0; b_seed_val = 0; b_start = 0; b_num = 0; b_hold = 0;
    b_ready = 0;
    s_rst_n = 0; s_seed_load = 0; s_seed_val = 0; s_start = 0; s_num = 0; s_hold = 0;
    s_ready = 0;
    #12;
    check("rst_valid", 160'(b_valid), 160'(0));
    check("rst_data",  160'(b_data),  160'(0));
    check("rst_cnt",   160'(b_cnt),   160'(0));
    check("rst_busy",  160'(b_busy),  160'(0));
    check("rst_done",  160'(b_done),  160'(0));
    b_rst_n = 1; s_rst_n = 1;
    tick();

    // 137-bit run of 100 with random backpressure
    m_st = SEED;
    for (int i = 0; i < 100; i++) exp_q.push_back(gen_vec(137, m_st));
    b_start = 1; b_num = 32'd100;
    tick();
    b_start = 0;
    run_vecs(1, 100, 0, 1, 5000);
    check("big_done",  160'(b_done),  160'(1));
    check("big_cnt",   160'(b_cnt),   160'(100));
    check("big_valid", 160'(b_valid), 160'(0));

    // Seed 0 with same-cycle start, one vector, latency NW+1
    exp_q.delete();
    m_st = 32'd0;
    exp_q.push_back(gen_vec(64, m_st));
    s_seed_load = 1; s_seed_val = 32'd0; s_start = 1; s_num = 4'd1;
    tick();
    s_seed_load = 0; s_start = 0;
    check("lat_busy",   160'(s_busy),  160'(1));
    check("lat_c1",     160'(s_valid), 160'(0));
    tick();
    check("lat_c2",     160'(s_valid), 160'(0));
    tick();
    check("lat_c3",     160'(s_valid), 160'(1));
    check("vec1_const", 160'(s_data),  160'(64'hD3DC167E00003039));
    run_vecs(0, 1, 0, 0, 10);
    check("one_done",  160'(s_done),  160'(1));
    check("one_cnt",   160'(s_cnt),   160'(1));
    check("one_valid", 160'(s_valid), 160'(0));
    check("one_busy",  160'(s_busy),  160'(0));
`ifdef LCG_STIM_SIG_EN
    check("sig", 160'(s_sig), 160'(32'hD3DC2647));
`endif

    // Hold during first accept
    small_reset();
    m_st = 32'd0;
    v1 = gen_vec(64, m_st);
    v2 = gen_vec(64, m_st);
    exp_q.push_back(v1); exp_q.push_back(v1); exp_q.push_back(v2);
    s_seed_load = 1; s_seed_val = 32'd0; s_start = 1; s_num = 4'd3;
    tick();
    s_seed_load = 0; s_start = 0;
    run_vecs(0, 3, 1, 0, 50);
    check("hold_done", 160'(s_done), 160'(1));
    check("hold_cnt",  160'(s_cnt),  160'(3));

    // Unlimited run, counter wraps
    small_reset();
    m_st = SEED;
    for (int i = 0; i < 20; i++) exp_q.push_back(gen_vec(64, m_st));
    s_start = 1; s_num = 4'd0;
    tick();
    s_start = 0;
    run_vecs(0, 20, 0, 0, 200);
    check("wrap_cnt",  160'(s_cnt),  160'(4));
    check("wrap_done", 160'(s_done), 160'(0));
    check("wrap_busy", 160'(s_busy), 160'(1));

    // Reset during FILL of vector 2
    small_reset();
    m_st = SEED;
    v1 = gen_vec(64, m_st);
    exp_q.push_back(v1);
    s_start = 1; s_num = 4'd5;
    tick();
    s_start = 0;
    run_vecs(0, 1, 0, 0, 20);
    check("mid_busy", 160'(s_busy), 160'(1));
    s_rst_n = 0;
    #1;
    check("mr_valid", 160'(s_valid), 160'(0));
    check("mr_data",  160'(s_data),  160'(0));
    check("mr_cnt",   160'(s_cnt),   160'(0));
    check("mr_busy",  160'(s_busy),  160'(0));
    check("mr_done",  160'(s_done),  160'(0));
    s_rst_n = 1;
    tick();
    exp_q.delete();
    exp_q.push_back(v1);
    s_start = 1; s_num = 4'd1;
    tick();
    s_start = 0;
    run_vecs(0, 1, 0, 0, 20);
    check("mr_rerun_done", 160'(s_done), 160'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
